// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the single-clock FIFO controller and its output stage.
package fifo_ctrl_pkg;

    typedef logic [1:0] stage_cnt_t;

    localparam stage_cnt_t STAGE_DEPTH = 2'd2;

    // Pointer difference modulo 2**pw, so wrapped pointers still give the occupancy.
    function automatic logic [31:0] ptr_diff(input logic [31:0] wptr,
                                             input logic [31:0] rptr,
                                             input int unsigned pw);
        logic [31:0] mask;
        mask = (32'd1 << pw) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// Two-entry registered output buffer that absorbs the memory read latency.
module fifo_out_stage
    import fifo_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         capture_i,
    input  logic [W-1:0] cap_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] head_o,
    output stage_cnt_t   cnt_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    stage_cnt_t   cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({capture_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = cap_data_i;
                else               tail_d = cap_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Head leaves while a word arrives: the new word lands behind whatever remains.
                if (cnt_q == STAGE_DEPTH) begin
                    head_d = tail_q;
                    tail_d = cap_data_i;
                end else begin
                    head_d = cap_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign head_o  = head_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_ctrl_sync.sv
// First-word-fall-through FIFO controller around a registered-read fifomem, with a 2-entry output stage.
module fifo_ctrl_sync
    import fifo_ctrl_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4,
    parameter int AF_LEVEL = (1 << ADDRSIZE)
) (
    input  logic                aclk,
    input  logic                srst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATASIZE-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATASIZE-1:0] out_data,
    output logic [ADDRSIZE+1:0] level,
    output logic                almost_full,
    output logic                mem_wclken,
    output logic [ADDRSIZE-1:0] mem_waddr,
    output logic [DATASIZE-1:0] mem_wdata,
    output logic                mem_wfull,
    output logic                mem_rclken,
    output logic [ADDRSIZE-1:0] mem_raddr,
    input  logic [DATASIZE-1:0] mem_rdata
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam int PW    = ADDRSIZE + 1;
    localparam int LW    = ADDRSIZE + 2;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0] mem_cnt, mem_cnt_d;
    logic [LW-1:0] level_q, level_d;
    logic          inflight_q, ready_q, almost_full_q;
    logic          clr, mem_full, wr_en, rd_issue, pop;
    stage_cnt_t    stage_cnt, stage_cnt_d;

    assign clr      = srst | flush;
    assign mem_cnt  = PW'(ptr_diff(32'(wptr_q), 32'(rptr_q), PW));
    assign mem_full = (mem_cnt == PW'(DEPTH));

    // A transfer happens on a side exactly when valid and ready are both high at the rising edge;
    // in_ready depends only on memory fullness, never on out_ready.
    assign in_ready = ready_q & ~mem_full & ~clr;
    assign wr_en    = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // Only issue a read if the stage can take it once the in-flight word and this cycle's pop settle.
    assign rd_issue = ~clr & (mem_cnt != '0) &
                      (({1'b0, stage_cnt} + {2'b00, inflight_q}) < ({1'b0, STAGE_DEPTH} + {2'b00, pop}));

    assign wptr_d      = wptr_q + PW'(wr_en);
    assign rptr_d      = rptr_q + PW'(rd_issue);
    assign mem_cnt_d   = PW'(ptr_diff(32'(wptr_d), 32'(rptr_d), PW));
    assign stage_cnt_d = stage_cnt + stage_cnt_t'(inflight_q) - stage_cnt_t'(pop);
    assign level_d     = LW'(mem_cnt_d) + LW'(rd_issue) + LW'(stage_cnt_d);

    always_ff @(posedge aclk) begin
        ready_q <= ~srst;
        if (clr) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            inflight_q    <= 1'b0;
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            inflight_q    <= rd_issue;
            level_q       <= level_d;
            almost_full_q <= (level_d >= LW'(AF_LEVEL));
        end
    end

    fifo_out_stage #(.W(DATASIZE)) u_out_stage (
        .clk_i      (aclk),
        .clr_i      (clr),
        .capture_i  (inflight_q),
        .cap_data_i (mem_rdata),
        .pop_i      (pop),
        .valid_o    (out_valid),
        .head_o     (out_data),
        .cnt_o      (stage_cnt)
    );

    assign level       = level_q;
    assign almost_full = almost_full_q;
    assign mem_wclken  = wr_en;
    assign mem_waddr   = wptr_q[ADDRSIZE-1:0];
    assign mem_wdata   = in_data;
    assign mem_wfull   = mem_full;
    assign mem_rclken  = rd_issue;
    assign mem_raddr   = rptr_q[ADDRSIZE-1:0];

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Bench for fifo_ctrl_sync: vector table, corner-case sequences and a randomized queue-model run.
module tb_fifo_ctrl_sync;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int LW    = AW + 2;
    localparam int NVEC  = 11;
    localparam int NRAND = 10000;

    logic          aclk = 1'b0;
    logic          srst, flush, in_valid, in_ready, out_valid, out_ready;
    logic          almost_full, mem_wclken, mem_wfull, mem_rclken;
    logic [DW-1:0] in_data, out_data, mem_wdata, mem_rdata;
    logic [LW-1:0] level;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ir;
        logic          ov;
        logic [DW-1:0] od;
        logic [LW-1:0] lv;
        logic          rc;
    } vec_t;

    vec_t vecs[NVEC];

    always #5 aclk = ~aclk;

    // Registered-read memory behaving like fifomem built with FALLTHROUGH="FALSE".
    always @(posedge aclk) begin
        if (mem_wclken) mem[mem_waddr] <= mem_wdata;
        if (mem_rclken) mem_rdata <= mem[mem_raddr];
    end

    fifo_ctrl_sync #(.DATASIZE(DW), .ADDRSIZE(AW), .AF_LEVEL(DEPTH)) dut (
        .aclk        (aclk),
        .srst        (srst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .almost_full (almost_full),
        .mem_wclken  (mem_wclken),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wfull   (mem_wfull),
        .mem_rclken  (mem_rclken),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
        check({tag, "_wclken"}, 32'(mem_wclken), 32'd0);
        check({tag, "_rclken"}, 32'(mem_rclken), 32'd0);
        check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
        check({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
        check({tag, "_wfull"}, 32'(mem_wfull), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        srst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge aclk);
        srst = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge aclk);
        #1;
        check("reset_ready_rise", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, got, n, wr_total, rd_total, cyc;
        bit found;
        logic [DW-1:0] exp_d;

        srst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        //                iv    id      ordy  ir    ov    od      lv     rc
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 6'd1, 1'b0};
        vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0};
        vecs[5]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd2, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 6'd2, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 6'd2, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 6'd1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0};

        do_reset();

        // Single-word latency and a two-word backpressure case.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge aclk);
            in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lv));
            check($sformatf("vec%0d_rclken", i), 32'(mem_rclken), 32'(vecs[i].rc));
            if (vecs[i].ov) check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
        end

        // Full-rate stream of 64 words.
        for (int c = 0; c < 67; c++) begin
            @(negedge aclk);
            in_valid = (c < 64); in_data = 8'(c); out_ready = 1'b1;
            #1;
            if (c < 64) check($sformatf("stream_in_ready_c%0d", c), 32'(in_ready), 32'd1);
            check($sformatf("stream_out_valid_c%0d", c), 32'(out_valid), 32'(c >= 3));
            if (c >= 3) check($sformatf("stream_data_c%0d", c), 32'(out_data), 32'(c - 3));
        end
        @(negedge aclk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("stream_drained", 32'(out_valid), 32'd0);

        // Fill with the consumer stalled.
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            in_valid = 1'b1; in_data = 8'h40 + 8'(acc); out_ready = 1'b0;
            #1;
            if (!in_ready) break;
            acc++;
        end
        check("fill_accepted", 32'(acc), 32'd18);
        check("fill_level", 32'(level), 32'd18);
        check("fill_almost_full", 32'(almost_full), 32'd1);
        check("fill_wfull", 32'(mem_wfull), 32'd1);
        got = 0;
        for (int i = 0; i < 40 && got < 18; i++) begin
            @(negedge aclk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                check($sformatf("fill_drain_%0d", got), 32'(out_data), 32'(8'h40 + 8'(got)));
                got++;
            end
        end
        check("fill_drain_count", 32'(got), 32'd18);
        @(negedge aclk);
        out_ready = 1'b0;
        #1;
        check("fill_empty_level", 32'(level), 32'd0);
        check("fill_empty_valid", 32'(out_valid), 32'd0);
        check("fill_empty_af", 32'(almost_full), 32'd0);

        // Flush with ten entries and a read in flight.
        for (int i = 0; i < 11; i++) begin
            @(negedge aclk);
            in_valid = 1'b1; in_data = 8'h80 + 8'(i); out_ready = 1'b0;
        end
        repeat (3) begin
            @(negedge aclk);
            in_valid = 1'b0; out_ready = 1'b0;
        end
        @(negedge aclk);
        out_ready = 1'b1;
        #1;
        check("flush_pre_head", 32'(out_data), 32'h80);
        check("flush_pre_issue", 32'(mem_rclken), 32'd1);
        @(negedge aclk);
        out_ready = 1'b0; flush = 1'b1;
        #1;
        check("flush_pre_level", 32'(level), 32'd10);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge aclk);
        flush = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_level", 32'(level), 32'd0);
        check("flush_af", 32'(almost_full), 32'd0);
        check("flush_waddr", 32'(mem_waddr), 32'd0);
        check("flush_raddr", 32'(mem_raddr), 32'd0);
        check("flush_in_ready_after", 32'(in_ready), 32'd1);
        n = 0; found = 1'b0;
        while (!found && n < 10) begin
            @(negedge aclk);
            in_valid = 1'b0; out_ready = 1'b0;
            #1;
            if (out_valid) found = 1'b1;
            else n++;
        end
        check("flush_first_seen", 32'(found), 32'd1);
        check("flush_first_latency", 32'(n + 1), 32'd3);
        check("flush_first_data", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            out_ready = 1'b0;
            #1;
            check($sformatf("flush_no_leak_valid_%0d", i), 32'(out_valid), 32'd0);
            check($sformatf("flush_no_leak_level_%0d", i), 32'(level), 32'd0);
        end

        // Synchronous reset in the middle of a stream.
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            in_valid = 1'b1; in_data = 8'hC0 + 8'(i); out_ready = 1'b1;
        end
        @(negedge aclk);
        srst = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        #1;
        check("srst_in_ready", 32'(in_ready), 32'd0);
        check("srst_wclken", 32'(mem_wclken), 32'd0);
        @(negedge aclk);
        srst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check_all_zero("srst_after");
        @(negedge aclk);
        #1;
        check("srst_ready_rise", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            out_ready = 1'b1;
            #1;
            check($sformatf("srst_empty_valid_%0d", i), 32'(out_valid), 32'd0);
            check($sformatf("srst_empty_level_%0d", i), 32'(level), 32'd0);
        end

        // Random traffic against an ordered queue of accepted words.
        exp_q.delete();
        wr_total = 0; rd_total = 0; cyc = 0;
        while (rd_total < NRAND && cyc < 45000) begin
            @(negedge aclk);
            in_valid  = (wr_total < NRAND) ? ($urandom_range(0, 1) == 1) : 1'b0;
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            check("rnd_level", 32'(level), 32'(exp_q.size()));
            check("rnd_af", 32'(almost_full), 32'(exp_q.size() >= DEPTH));
            check("rnd_waddr", 32'(mem_waddr), 32'(wr_total % DEPTH));
            if (exp_q.size() < DEPTH) check("rnd_in_ready_room", 32'(in_ready), 32'd1);
            if (exp_q.size() == DEPTH + 2) check("rnd_in_ready_full", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) check("rnd_empty_valid", 32'(out_valid), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_pop_nonempty", 32'd0, 32'd1);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("rnd_data", 32'(out_data), 32'(exp_d));
                end
                rd_total++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                wr_total++;
            end
            cyc++;
        end
        check("rnd_words_out", 32'(rd_total), 32'(NRAND));
        check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_sync.md
# fifo_ctrl_sync

Single-clock controller that sequences one `fifomem` instance, built with `FALLTHROUGH="FALSE"` (registered read, 1-cycle read latency), into a first-word-fall-through FIFO with valid/ready on both sides. It owns the write and read pointers, full/empty/level tracking and read issue. It also contains a 2-entry output stage that hides the memory read latency, so the FIFO sustains one transfer per cycle under backpressure. It sits between AXI crossbar channel producers and consumers wherever a deep, RAM-backed single-clock buffer is needed.

## Interface
- `DATASIZE`, 8: payload width.
- `ADDRSIZE`, 4: memory address bits; memory depth `DEPTH = 1<<ADDRSIZE`.
- `AF_LEVEL`, `DEPTH`: `almost_full` threshold on `level`.
- `aclk`  in  1  single clock; all logic on rising edge.
- `srst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous clear of all contents; does not reset configuration.
- `in_valid`  in  1  write request.
- `in_ready`  out  1  write accepted when `in_valid & in_ready`.
- `in_data`  in  DATASIZE  write payload.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer pop when `out_valid & out_ready`.
- `out_data`  out  DATASIZE  head payload, registered.
- `level`  out  ADDRSIZE+2  memory entries + in-flight read + staged entries (max `DEPTH+2`).
- `almost_full`  out  1  `level >= AF_LEVEL`, registered.
- `mem_wclken`  out  1  to `fifomem.wclken`.
- `mem_waddr`  out  ADDRSIZE  to `fifomem.waddr`.
- `mem_wdata`  out  DATASIZE  to `fifomem.wdata` (equal to `in_data`).
- `mem_wfull`  out  1  to `fifomem.wfull`.
- `mem_rclken`  out  1  to `fifomem.rclken` (read issue).
- `mem_raddr`  out  ADDRSIZE  to `fifomem.raddr`.
- `mem_rdata`  in  DATASIZE  from `fifomem.rdata`; valid in the cycle after issue.

## Operation
- **Pointers:** `wptr`, `rptr` are ADDRSIZE+1 bits and wrap naturally. `mem_cnt = wptr - rptr`. Memory is full when `mem_cnt == DEPTH` and empty when `mem_cnt == 0`. `mem_waddr`/`mem_raddr` are the low ADDRSIZE bits.
- **Write:**
  - `in_ready = !mem_full & !flush & !srst`. It never depends on `out_ready`, so there is no combinational in→out path.
  - On accept: `mem_wclken=1`, `wptr++`. `mem_wfull` mirrors `mem_full`.
- **Read issue:**
  - Issue when `mem_cnt != 0 & (stage_cnt + inflight - pop) < 2`.
  - On issue: `mem_rclken=1`, `rptr++`, and set `inflight` for one cycle.
- **Capture:** in the cycle where `inflight=1`, `mem_rdata` is written into the output stage tail.
- **Output stage:**
  - 2-entry register FIFO (`stage_cnt` 0..2).
  - `out_valid = stage_cnt != 0`, and `out_data` is the head entry.
  - Pop and capture may occur in the same cycle.
- **Flush:**
  - `wptr=rptr=0`, `stage_cnt=0`, `inflight=0`.
  - A read issued the cycle before flush is discarded.
  - Takes effect in the cycle after `flush` is asserted.
- **Reset:** same as flush. Outputs after reset:
  - 0: `in_ready`, `out_valid`, `out_data`, `level`, `almost_full`, `mem_*` enables, addresses.
  - `in_ready` rises the cycle after `srst` deasserts.
- **Simultaneous write and issue to the same address:** legal. The write commits at the end of cycle t, and a read of that address is issued no earlier than t+1.

## Timing
- Empty-to-output latency: write accepted in cycle t → read issued t+1 → captured end of t+2 → `out_valid=1` in t+3.
- Steady-state throughput is 1 word/cycle with `out_ready` held high. The 2-entry stage absorbs the single in-flight word when `out_ready` drops.
- `level` and `almost_full` update the cycle after the causing handshake.
- Maximum occupancy is `DEPTH+2`; `in_ready` deasserts only on memory full.

## Structure
- Shared package `fifo_ctrl_pkg` holds:
  - the stage-count type (2 bits);
  - the function computing pointer difference with wrap.
- Natural sub-module: `fifo_out_stage`, the 2-entry registered output buffer with capture/pop and `stage_cnt`.
- Top-level instantiates `fifo_out_stage`. `fifomem` is instantiated by the integrating wrapper, not inside this block.

## Test plan
- Reset, then write 0xA5 at cycle 0 → `out_valid` at cycle 3 with `out_data=0xA5`; `level` goes 1 → 1 → 1 → 0 after pop.
- Stream 64 incrementing bytes with `out_ready=1`, DEPTH=16 → all 64 received in order, one per cycle after the 3-cycle fill, and `in_ready` never drops.
- Hold `out_ready=0` and write until `in_ready=0` → exactly 18 accepted (16 mem + 2 stage), `level=18`, `almost_full=1`. Then release → 18 words out in order.
- Random `in_valid`/`out_ready` (50%) over 10k words → scoreboard match, no loss or duplication, and `wptr`/`rptr` wrap verified.
- Assert `flush` with 10 entries and a read in flight → next cycle `out_valid=0`, `level=0`. The following write of 0x3C appears as the first output.
- Assert `srst` mid-stream with `in_valid=1` → no write accepted that cycle, all outputs 0 the next cycle, and the FIFO is empty after release.
